// File: rtl/patbuf_serial_ctrl.sv
// Serial controller for the low/high pattern buffers: shifts one addressed word MSB first
// to or from the selected buffer, with registered strobes and an abort path.
module patbuf_serial_ctrl #(
    parameter int unsigned D_WIDTH = 8,
    parameter int unsigned DIV     = 2
) (
    input  logic               clk_int,
    input  logic               reset,
    input  logic               req,
    input  logic               req_wr,
    input  logic               req_high,
    input  logic [2:0]         req_addr,
    input  logic [D_WIDTH-1:0] req_data,
    input  logic               abort,
    input  logic               sout_low,
    input  logic               sout_high,
    output logic               sclk_low,
    output logic               sclk_high,
    output logic               ssel_low,
    output logic               ssel_high,
    output logic               sin_low,
    output logic               sin_high,
    output logic [2:0]         saddr_low,
    output logic [2:0]         saddr_high,
    output logic               busy,
    output logic               ack,
    output logic [D_WIDTH-1:0] rd_data,
    output logic               err
);

    localparam int unsigned     BitW      = $clog2(D_WIDTH + 1);
    localparam logic [3:0]      PhaseLast = 4'(DIV - 1);
    localparam logic [BitW-1:0] BitLast   = BitW'(D_WIDTH - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StShiftLo,
        StShiftHi,
        StHold,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [3:0]         phase_q, phase_d;
    logic [BitW-1:0]    bit_q, bit_d;
    logic               wr_q, wr_d;
    logic               sel_hi_q, sel_hi_d;
    logic [2:0]         addr_q, addr_d;
    logic [D_WIDTH-1:0] sr_q, sr_d;
    logic [D_WIDTH-1:0] cap_q, cap_d;
    logic [D_WIDTH-1:0] rd_data_q, rd_data_d;
    logic               busy_q, busy_d;
    logic               ack_q, ack_d;
    logic               err_q, err_d;
    // Strobe bundle per buffer: {sclk, ssel, sin, saddr[2:0]}
    logic [5:0]         lo_q, lo_d;
    logic [5:0]         hi_q, hi_d;

    logic [5:0]         strobe;
    logic               sout_sel;
    logic               cur_bit;

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        bit_d     = bit_q;
        wr_d      = wr_q;
        sel_hi_d  = sel_hi_q;
        addr_d    = addr_q;
        sr_d      = sr_q;
        cap_d     = cap_q;
        rd_data_d = rd_data_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        strobe    = 6'b0;
        sout_sel  = sel_hi_q ? sout_high : sout_low;
        cur_bit   = wr_q & sr_q[D_WIDTH-1];

        unique case (state_q)
            StIdle: begin
                if (req) begin
                    wr_d     = req_wr;
                    sel_hi_d = req_high;
                    addr_d   = req_addr;
                    sr_d     = req_data;
                    cap_d    = '0;
                    phase_d  = 4'd0;
                    bit_d    = '0;
                    state_d  = StSetup;
                end
            end
            StSetup: begin
                strobe = {1'b0, 1'b1, 1'b0, addr_q};
                if (phase_q == PhaseLast) begin
                    phase_d = 4'd0;
                    state_d = StShiftLo;
                end else begin
                    phase_d = phase_q + 4'd1;
                end
            end
            StShiftLo: begin
                strobe = {1'b0, 1'b1, cur_bit, addr_q};
                if (phase_q == PhaseLast) begin
                    phase_d = 4'd0;
                    state_d = StShiftHi;
                end else begin
                    phase_d = phase_q + 4'd1;
                end
            end
            StShiftHi: begin
                strobe = {1'b1, 1'b1, cur_bit, addr_q};
                // Sample on the edge that raises the registered sclk
                if (phase_q == 4'd0 && !wr_q) begin
                    cap_d = (cap_q << 1) | D_WIDTH'(sout_sel);
                end
                if (phase_q == PhaseLast) begin
                    phase_d = 4'd0;
                    sr_d    = sr_q << 1;
                    if (bit_q == BitLast) begin
                        state_d = StHold;
                    end else begin
                        bit_d   = bit_q + BitW'(1);
                        state_d = StShiftLo;
                    end
                end else begin
                    phase_d = phase_q + 4'd1;
                end
            end
            StHold: begin
                strobe = {1'b0, 1'b1, 1'b0, addr_q};
                if (phase_q == PhaseLast) begin
                    phase_d = 4'd0;
                    state_d = StDone;
                end else begin
                    phase_d = phase_q + 4'd1;
                end
            end
            StDone: begin
                ack_d   = 1'b1;
                state_d = StIdle;
                if (!wr_q) begin
                    rd_data_d = cap_q;
                end
            end
            default: state_d = StIdle;
        endcase

        if (abort && state_q != StIdle) begin
            state_d   = StIdle;
            phase_d   = 4'd0;
            bit_d     = '0;
            strobe    = 6'b0;
            ack_d     = 1'b0;
            err_d     = 1'b1;
            rd_data_d = rd_data_q;
        end

        busy_d = (state_d != StIdle);
        lo_d   = sel_hi_q ? 6'b0 : strobe;
        hi_d   = sel_hi_q ? strobe : 6'b0;
    end

    always_ff @(posedge clk_int or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            phase_q   <= 4'd0;
            bit_q     <= '0;
            wr_q      <= 1'b0;
            sel_hi_q  <= 1'b0;
            addr_q    <= 3'd0;
            sr_q      <= '0;
            cap_q     <= '0;
            rd_data_q <= '0;
            busy_q    <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            lo_q      <= 6'b0;
            hi_q      <= 6'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            bit_q     <= bit_d;
            wr_q      <= wr_d;
            sel_hi_q  <= sel_hi_d;
            addr_q    <= addr_d;
            sr_q      <= sr_d;
            cap_q     <= cap_d;
            rd_data_q <= rd_data_d;
            busy_q    <= busy_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            lo_q      <= lo_d;
            hi_q      <= hi_d;
        end
    end

    assign sclk_low   = lo_q[5];
    assign ssel_low   = lo_q[4];
    assign sin_low    = lo_q[3];
    assign saddr_low  = lo_q[2:0];
    assign sclk_high  = hi_q[5];
    assign ssel_high  = hi_q[4];
    assign sin_high   = hi_q[3];
    assign saddr_high = hi_q[2:0];
    assign busy       = busy_q;
    assign ack        = ack_q;
    assign err        = err_q;
    assign rd_data    = rd_data_q;

endmodule

// File: tb/tb_patbuf_serial_ctrl.sv
// Directed bench for patbuf_serial_ctrl: default instance plus a DIV=1 instance, each
// buffer backed by a shift-out slave that presents the next bit after every sclk rise.
module tb_patbuf_serial_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       req, req1, req_wr, req_high, abort;
    logic [2:0] req_addr;
    logic [7:0] req_data;
    logic       sout_low, sout_high, sout_low1;
    logic       sclk_low, sclk_high, ssel_low, ssel_high, sin_low, sin_high;
    logic [2:0] saddr_low, saddr_high;
    logic       busy, ack, err;
    logic [7:0] rd_data;
    logic       sclk_low1, sclk_high1, ssel_low1, ssel_high1, sin_low1, sin_high1;
    logic [2:0] saddr_low1, saddr_high1;
    logic       busy1, ack1, err1;
    logic [7:0] rd_data1;
    logic       tie0 = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    patbuf_serial_ctrl u_dut (
        .clk_int(clk), .reset(reset), .req(req), .req_wr(req_wr), .req_high(req_high),
        .req_addr(req_addr), .req_data(req_data), .abort(abort),
        .sout_low(sout_low), .sout_high(sout_high),
        .sclk_low(sclk_low), .sclk_high(sclk_high), .ssel_low(ssel_low), .ssel_high(ssel_high),
        .sin_low(sin_low), .sin_high(sin_high), .saddr_low(saddr_low), .saddr_high(saddr_high),
        .busy(busy), .ack(ack), .rd_data(rd_data), .err(err)
    );

    patbuf_serial_ctrl #(.D_WIDTH(8), .DIV(1)) u_dut1 (
        .clk_int(clk), .reset(reset), .req(req1), .req_wr(req_wr), .req_high(req_high),
        .req_addr(req_addr), .req_data(req_data), .abort(abort),
        .sout_low(sout_low1), .sout_high(tie0),
        .sclk_low(sclk_low1), .sclk_high(sclk_high1), .ssel_low(ssel_low1),
        .ssel_high(ssel_high1), .sin_low(sin_low1), .sin_high(sin_high1),
        .saddr_low(saddr_low1), .saddr_high(saddr_high1),
        .busy(busy1), .ack(ack1), .rd_data(rd_data1), .err(err1)
    );

    // Slave models: bit n of the pattern (MSB first) is presented until the n-th sclk rise
    logic [7:0] pat_lo = 8'h00, pat_hi = 8'h00, pat_lo1 = 8'h00;
    int lo_cnt = 0, hi_cnt = 0, lo1_cnt = 0;
    int lo_base = 0, hi_base = 0, lo1_base = 0;

    always @(posedge sclk_low)  lo_cnt  <= lo_cnt + 1;
    always @(posedge sclk_high) hi_cnt  <= hi_cnt + 1;
    always @(posedge sclk_low1) lo1_cnt <= lo1_cnt + 1;

    function automatic logic pick(input logic [7:0] p, input int n);
        if (n >= 0 && n < 8) return p[7-n];
        return 1'b0;
    endfunction

    assign sout_low  = pick(pat_lo, lo_cnt - lo_base);
    assign sout_high = pick(pat_hi, hi_cnt - hi_base);
    assign sout_low1 = pick(pat_lo1, lo1_cnt - lo1_base);

    // Called at posedge+1; returns at posedge+1 right after the acceptance edge
    task automatic start(input logic wr, input logic hi, input logic [2:0] addr,
                         input logic [7:0] data);
        req_wr = wr; req_high = hi; req_addr = addr; req_data = data; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; req = 0; req1 = 0; req_wr = 0; req_high = 0; abort = 0;
        req_addr = 0; req_data = 0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
        total++; if (ack !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL reset_ack_err got %b%b want 00", ack, err); end
        total++; if (rd_data !== 8'h00) begin bad++; $display("FAIL reset_rd_data got %h want 00", rd_data); end
        total++; if ({sclk_low, ssel_low, sin_low, saddr_low, sclk_high, ssel_high, sin_high, saddr_high} !== 12'h0)
            begin bad++; $display("FAIL reset_strobes got nonzero want 0"); end
        total++; if (busy1 !== 1'b0 || rd_data1 !== 8'h00) begin bad++; $display("FAIL reset_dut1 got busy=%b rd=%h want 0/00", busy1, rd_data1); end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_write_low;
        int lat = 0, ssel_cnt = 0, rises = 0, hi_bad = 0, addr_bad = 0;
        logic [7:0] bits = 8'h00;
        logic prev = 1'b0;
        start(1'b1, 1'b0, 3'd5, 8'hA5);
        for (int n = 1; n <= 60 && lat == 0; n++) begin
            @(posedge clk); #1;
            if (ssel_low) ssel_cnt++;
            if (ssel_low && saddr_low !== 3'd5) addr_bad++;
            if (sclk_low && !prev) begin rises++; bits = {bits[6:0], sin_low}; end
            prev = sclk_low;
            if ({sclk_high, ssel_high, sin_high, saddr_high} !== 6'h0) hi_bad++;
            if (ack) lat = n;
        end
        total++; if (lat !== 37) begin bad++; $display("FAIL wr_latency got %0d want 37", lat); end
        total++; if (ssel_cnt !== 36) begin bad++; $display("FAIL wr_ssel_cycles got %0d want 36", ssel_cnt); end
        total++; if (rises !== 8) begin bad++; $display("FAIL wr_sclk_rises got %0d want 8", rises); end
        total++; if (bits !== 8'hA5) begin bad++; $display("FAIL wr_sin_bits got %h want a5", bits); end
        total++; if (addr_bad !== 0) begin bad++; $display("FAIL wr_saddr got %0d bad cycles want 0", addr_bad); end
        total++; if (hi_bad !== 0) begin bad++; $display("FAIL wr_high_quiet got %0d bad cycles want 0", hi_bad); end
        total++; if (busy !== 1'b0 || rd_data !== 8'h00) begin bad++; $display("FAIL wr_ack_cycle got busy=%b rd=%h want 0/00", busy, rd_data); end
    endtask

    task automatic test_read_high;
        int lat = 0, sin_bad = 0, lo_bad = 0;
        logic [7:0] mid_rd = 8'hxx;
        pat_hi = 8'h3C; hi_base = hi_cnt;
        start(1'b0, 1'b1, 3'd2, 8'hFF);
        for (int n = 1; n <= 60 && lat == 0; n++) begin
            @(posedge clk); #1;
            if (sin_high) sin_bad++;
            if ({sclk_low, ssel_low, sin_low, saddr_low} !== 6'h0) lo_bad++;
            if (n == 20) mid_rd = rd_data;
            if (ack) lat = n;
        end
        total++; if (lat !== 37) begin bad++; $display("FAIL rd_latency got %0d want 37", lat); end
        total++; if (rd_data !== 8'h3C) begin bad++; $display("FAIL rd_data got %h want 3c", rd_data); end
        total++; if (mid_rd !== 8'h00) begin bad++; $display("FAIL rd_data_held got %h want 00", mid_rd); end
        total++; if (sin_bad !== 0) begin bad++; $display("FAIL rd_sin_zero got %0d bad cycles want 0", sin_bad); end
        total++; if (lo_bad !== 0) begin bad++; $display("FAIL rd_low_quiet got %0d bad cycles want 0", lo_bad); end
    endtask

    task automatic test_back_to_back;
        int acks = 0, a1 = 0, a2 = 0;
        req_wr = 1'b1; req_high = 1'b0; req_addr = 3'd1; req_data = 8'h5A; req = 1'b1;
        @(posedge clk); #1;
        req_data = 8'hC3;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk); #1;
            if (ack) begin acks++; if (a1 == 0) a1 = n; else a2 = n; end
            if (n == 37) begin
                total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_idle_gap got busy=%b want 0", busy); end
            end
            if (n == 38) begin
                total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_reaccept got busy=%b want 1", busy); end
            end
            if (n == 39) begin
                total++; if (ssel_low !== 1'b1) begin bad++; $display("FAIL b2b_setup got ssel=%b want 1", ssel_low); end
            end
            req = (n < 38) || (n == 50) || (n == 60);
        end
        req = 1'b0;
        total++; if (acks !== 2) begin bad++; $display("FAIL b2b_ack_count got %0d want 2", acks); end
        total++; if (a1 !== 37 || a2 !== 75) begin bad++; $display("FAIL b2b_ack_times got %0d,%0d want 37,75", a1, a2); end
    endtask

    task automatic test_abort;
        int rises = 0, acks = 0, errs = 0;
        logic prev = 1'b0, done = 1'b0;
        pat_hi = 8'hF0; hi_base = hi_cnt;
        start(1'b0, 1'b1, 3'd6, 8'h00);
        for (int n = 1; n <= 60 && !done; n++) begin
            @(posedge clk); #1;
            if (sclk_high && !prev) begin
                rises++;
                if (rises == 4) begin
                    abort = 1'b1;
                    @(posedge clk); #1;
                    abort = 1'b0;
                    done = 1'b1;
                    total++; if ({sclk_high, ssel_high, sin_high, saddr_high} !== 6'h0)
                        begin bad++; $display("FAIL abort_strobes got %b%b%b%h want 0", sclk_high, ssel_high, sin_high, saddr_high); end
                    total++; if (err !== 1'b1 || ack !== 1'b0) begin bad++; $display("FAIL abort_err got err=%b ack=%b want 1/0", err, ack); end
                    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got %b want 0", busy); end
                end
            end
            prev = sclk_high;
        end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL abort_reached got %b want 1", done); end
        for (int n = 0; n < 50; n++) begin
            @(posedge clk); #1;
            if (ack) acks++;
            if (err) errs++;
        end
        total++; if (acks !== 0 || errs !== 0) begin bad++; $display("FAIL abort_after got ack=%0d err=%0d want 0/0", acks, errs); end
        total++; if (rd_data !== 8'h3C) begin bad++; $display("FAIL abort_rd_held got %h want 3c", rd_data); end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        total++; if (err !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL abort_idle got err=%b busy=%b want 0/0", err, busy); end
    endtask

    task automatic test_async_reset;
        int lat = 0;
        pat_hi = 8'hA5; hi_base = hi_cnt;
        start(1'b0, 1'b1, 3'd7, 8'h00);
        repeat (10) @(posedge clk);
        #4;
        reset = 1'b1;
        #1;
        total++; if (busy !== 1'b0 || ack !== 1'b0) begin bad++; $display("FAIL arst_busy got busy=%b ack=%b want 0/0", busy, ack); end
        total++; if ({sclk_high, ssel_high, sin_high, saddr_high} !== 6'h0) begin bad++; $display("FAIL arst_strobes got nonzero want 0"); end
        total++; if (rd_data !== 8'h00) begin bad++; $display("FAIL arst_rd_data got %h want 00", rd_data); end
        @(posedge clk); #3;
        reset = 1'b0;
        @(posedge clk); #1;
        pat_hi = 8'hFF; hi_base = hi_cnt;
        start(1'b0, 1'b1, 3'd4, 8'h00);
        for (int n = 1; n <= 60 && lat == 0; n++) begin
            @(posedge clk); #1;
            if (ack) lat = n;
        end
        total++; if (lat !== 37) begin bad++; $display("FAIL arst_latency got %0d want 37", lat); end
        total++; if (rd_data !== 8'hFF) begin bad++; $display("FAIL arst_rd_data_after got %h want ff", rd_data); end
    endtask

    task automatic test_div1;
        int lat = 0;
        pat_lo1 = 8'h96; lo1_base = lo1_cnt;
        req_wr = 1'b0; req_high = 1'b0; req_addr = 3'd3; req1 = 1'b1;
        @(posedge clk); #1;
        req1 = 1'b0;
        for (int n = 1; n <= 40 && lat == 0; n++) begin
            @(posedge clk); #1;
            if (ack1) lat = n;
        end
        total++; if (lat !== 19) begin bad++; $display("FAIL div1_latency got %0d want 19", lat); end
        total++; if (rd_data1 !== 8'h96) begin bad++; $display("FAIL div1_rd_data got %h want 96", rd_data1); end
    endtask

    initial begin
        test_reset();
        test_write_low();
        test_read_high();
        test_back_to_back();
        test_abort();
        test_async_reset();
        test_div1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/patbuf_serial_ctrl.md
PATBUF_SERIAL_CTRL -- requirements
Module: patbuf_serial_ctrl

Interface
REQ-001 SHALL have parameter D_WIDTH, default 8, meaning serial word length in bits.
REQ-002 SHALL have parameter DIV, default 2, meaning sclk half-period in clk_int cycles (legal range 1..15).
REQ-003 SHALL have port clk_int  in  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port req  in  1  transaction request, level, sampled only in IDLE.
REQ-006 SHALL have port req_wr  in  1  1 = write, 0 = read.
REQ-007 SHALL have port req_high  in  1  0 = low pattern buffer, 1 = high pattern buffer.
REQ-008 SHALL have port req_addr  in  3  serial register address.
REQ-009 SHALL have port req_data  in  D_WIDTH  write data.
REQ-010 SHALL have port abort  in  1  synchronous cancel of the current transaction.
REQ-011 SHALL have ports sout_low, sout_high  in  1 each  serial data returned from each buffer.
REQ-012 SHALL have ports sclk_low, sclk_high, ssel_low, ssel_high, sin_low, sin_high  out  1 each  serial strobes per buffer.
REQ-013 SHALL have ports saddr_low, saddr_high  out  3 each  serial address per buffer.
REQ-014 SHALL have port busy  out  1  high in every state except IDLE.
REQ-015 SHALL have port ack  out  1  one-cycle completion pulse.
REQ-016 SHALL have port rd_data  out  D_WIDTH  last completed read word.
REQ-017 SHALL have port err  out  1  one-cycle pulse on abort.

Function
REQ-018 SHALL implement FSM IDLE -> SETUP -> SHIFT_LO <-> SHIFT_HI -> HOLD -> DONE -> IDLE; all serial outputs registered.
REQ-019 SHALL accept in IDLE when req=1: capture req_wr/req_high/req_addr/req_data on that edge, enter SETUP next cycle.
REQ-020 SHALL hold SETUP for DIV cycles: ssel=1, saddr=captured address, sclk=0, sin=0.
REQ-021 SHALL shift D_WIDTH bits MSB first; per bit SHIFT_LO DIV cycles (sclk=0, sin=bit; sin=0 for reads), then SHIFT_HI DIV cycles (sclk=1, sin held).
REQ-022 SHALL, on reads, sample the selected sout on the first cycle of each SHIFT_HI into a capture shift register, MSB first.
REQ-023 SHALL hold HOLD for DIV cycles (ssel=1, sclk=0), then DONE for 1 cycle (ssel=0, ack=1), then IDLE.
REQ-024 SHALL give latency from acceptance edge to ack = 2*DIV*(D_WIDTH+1)+1 cycles (37 at defaults).
REQ-025 SHALL update rd_data in the DONE cycle of reads only; rd_data is held otherwise.
REQ-026 SHALL drive only the buffer selected by the captured req_high; all outputs of the other buffer are 0 throughout.
REQ-027 SHALL select sout by captured req_high, not the live input.
REQ-028 SHALL ignore req while busy=1; no queuing. req held high through DONE starts a new transaction on the first IDLE cycle.
REQ-029 SHALL, on abort=1 in any non-IDLE state, enter IDLE next cycle with sclk/ssel/sin/saddr=0, err=1 for that cycle, no ack, rd_data unchanged; abort in IDLE is ignored.
REQ-030 SHALL give abort priority over a simultaneous state transition, including in DONE (ack is suppressed).
REQ-031 SHALL count bits with a counter of width clog2(D_WIDTH+1) and phases with a 4-bit counter; no wrap-around beyond terminal counts.

Reset
REQ-032 SHALL, while reset=1, asynchronously force state IDLE, all serial outputs 0, busy=0, ack=0, err=0, rd_data=0, counters 0.
REQ-033 SHALL discard any in-flight transaction on reset; after reset release, the first req is accepted normally.

Verification
REQ-034 Write low: req_wr=1, req_high=0, addr=5, data=0xA5 -> ssel_low high 36 cycles, sin_low bits 1,0,1,0,0,1,0,1 on 8 sclk_low rises, saddr_low=5, all high-buffer outputs 0, ack at cycle 37.
REQ-035 Read high: req_wr=0, req_high=1, addr=2, sout_high model returns 0x3C -> rd_data=0x3C in the ack cycle, sin_high=0 throughout, low-buffer outputs 0.
REQ-036 Back-to-back: req held high across two writes -> second SETUP starts on the first IDLE cycle after DONE; req pulses during busy produce no extra ack.
REQ-037 Abort at 4th SHIFT_HI -> next cycle all strobes 0, err=1, no ack, rd_data unchanged from prior value.
REQ-038 Async reset asserted mid-read (between clock edges) -> outputs 0 immediately; subsequent read of 0xFF completes with correct rd_data.
REQ-039 DIV=1 read with D_WIDTH=8 -> ack exactly 19 cycles after acceptance.
